// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbitration blocks.
package stream_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays legal when only one or two entries exist.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular-priority picker: first set bit of req at or after ptr.
module rr_pick #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = 2
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic               grant_vld,
  output logic [IdWidth-1:0] grant_id
);

  logic [IdWidth-1:0] idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdWidth'((32'(ptr) + i) % NumReq);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered valid/ready stream;
// the requester ID travels with every beat.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned WordWidth = 64,
  parameter int unsigned IdWidth   = clog2_min1(NumReq)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NumReq-1:0]           req_vld_i,
  input  logic [NumReq*WordWidth-1:0] req_payload_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           req_rdy_o,
  output logic                        deq_vld_o,
  output logic [WordWidth-1:0]        deq_payload_o,
  output logic                        deq_last_o,
  output logic [IdWidth-1:0]          deq_id_o,
  input  logic                        deq_rdy_i,
  input  logic                        flush_i
);

  arb_state_e         state_q, state_d;
  logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;

  logic               pick_vld;
  logic [IdWidth-1:0] pick_id;
  logic               grant_vld;
  logic [IdWidth-1:0] grant_id;
  logic               accept_en;
  logic               beat_acc;
  logic               beat_last;

  logic [WordWidth-1:0] payload_arr [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign payload_arr[i] = req_payload_i[i*WordWidth +: WordWidth];
  end

  function automatic logic [IdWidth-1:0] inc_wrap(input logic [IdWidth-1:0] v);
    return (32'(v) == NumReq - 1) ? '0 : v + IdWidth'(1);
  endfunction

  rr_pick #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_pick (
    .req       (req_vld_i),
    .ptr       (rr_ptr_q),
    .grant_vld (pick_vld),
    .grant_id  (pick_id)
  );

  assign accept_en = (~deq_vld_o | deq_rdy_i) & ~flush_i;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Grant selection and ready fan-out; a locked packet owns the stream even when idle
  always_comb begin
    grant_vld = pick_vld;
    grant_id  = pick_id;
    req_rdy_o = '0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_id  = lock_id_q;
    end
    if (grant_vld && accept_en) begin
      req_rdy_o[grant_id] = 1'b1;
    end
    beat_acc  = grant_vld & accept_en & req_vld_i[grant_id];
    beat_last = req_last_i[grant_id];
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (flush_i) begin
      state_d  = ARB;
      rr_ptr_d = '0;
    end else if (beat_acc) begin
      unique case (state_q)
        ARB: begin
          if (beat_last) begin
            rr_ptr_d = inc_wrap(grant_id);
          end else begin
            state_d   = LOCKED;
            lock_id_d = grant_id;
          end
        end
        LOCKED: begin
          if (beat_last) begin
            state_d  = ARB;
            rr_ptr_d = inc_wrap(lock_id_q);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Output beat register; flush wins over accept and drain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deq_vld_o     <= 1'b0;
      deq_payload_o <= '0;
      deq_last_o    <= 1'b0;
      deq_id_o      <= '0;
    end else if (flush_i) begin
      deq_vld_o <= 1'b0;
    end else if (beat_acc) begin
      deq_vld_o     <= 1'b1;
      deq_payload_o <= payload_arr[grant_id];
      deq_last_o    <= beat_last;
      deq_id_o      <= grant_id;
    end else if (deq_rdy_i) begin
      deq_vld_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NumReq=4, WordWidth=64).
module tb_stream_rr_arbiter;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned WordWidth = 64;
  localparam int unsigned IdWidth   = 2;

  logic                        clk;
  logic                        rstn;
  logic [NumReq-1:0]           req_vld;
  logic [NumReq*WordWidth-1:0] req_payload;
  logic [NumReq-1:0]           req_last;
  logic [NumReq-1:0]           req_rdy;
  logic                        deq_vld;
  logic [WordWidth-1:0]        deq_payload;
  logic                        deq_last;
  logic [IdWidth-1:0]          deq_id;
  logic                        deq_rdy;
  logic                        flush;

  int n_checks;
  int n_pass;

  stream_rr_arbiter #(
    .NumReq    (NumReq),
    .WordWidth (WordWidth),
    .IdWidth   (IdWidth)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_vld_i     (req_vld),
    .req_payload_i (req_payload),
    .req_last_i    (req_last),
    .req_rdy_o     (req_rdy),
    .deq_vld_o     (deq_vld),
    .deq_payload_o (deq_payload),
    .deq_last_o    (deq_last),
    .deq_id_o      (deq_id),
    .deq_rdy_i     (deq_rdy),
    .flush_i       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_pl(input int i, input logic [63:0] v);
    req_payload[i*WordWidth +: WordWidth] = v;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [1:0] id,
                           input logic [63:0] pl, input logic last);
    check({tag, "_vld"}, 64'(deq_vld), 64'(vld));
    check({tag, "_id"}, 64'(deq_id), 64'(id));
    check({tag, "_pl"}, deq_payload, pl);
    check({tag, "_last"}, 64'(deq_last), 64'(last));
  endtask

  task automatic check_rdy(input string tag, input logic [3:0] exp);
    #1;
    check(tag, 64'(req_rdy), 64'(exp));
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rstn        = 1'b0;
    req_vld     = '0;
    req_payload = '0;
    req_last    = '0;
    deq_rdy     = 1'b0;
    flush       = 1'b0;

    // Reset values
    @(negedge clk);
    check_out("reset", 1'b0, 2'd0, 64'h0, 1'b0);
    check_rdy("reset_rdy", 4'b0000);
    rstn = 1'b1;

    // Round robin: all valid, single-beat packets
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_pl(i, 64'h100 + 64'(i));
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    deq_rdy  = 1'b1;
    check("rr_pre_vld", 64'(deq_vld), 64'h0);
    check_rdy("rr_rdy0", 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_out("rr", 1'b1, 2'((k - 1) % 4), 64'h100 + 64'((k - 1) % 4), 1'b1);
      check_rdy("rr_rdy", 4'(1 << (k % 4)));
    end
    @(negedge clk);
    check_out("rr_end", 1'b1, 2'd0, 64'h100, 1'b1);
    req_vld = '0;
    check_rdy("rr_idle_rdy", 4'b0000);
    @(negedge clk);
    check("rr_drain", 64'(deq_vld), 64'h0);

    // Packet lock: req1 sends 3 beats while req0/req2 wait (rr_ptr=1)
    req_vld  = 4'b0111;
    req_last = 4'b0101;
    set_pl(1, 64'h210);
    check_rdy("lk_rdy0", 4'b0010);
    @(negedge clk);
    check_out("lk_b0", 1'b1, 2'd1, 64'h210, 1'b0);
    req_vld = 4'b0101;
    check_rdy("lk_idle_owner_rdy", 4'b0010);
    @(negedge clk);
    check("lk_gap_vld", 64'(deq_vld), 64'h0);
    req_vld = 4'b0111;
    set_pl(1, 64'h211);
    check_rdy("lk_rdy1", 4'b0010);
    @(negedge clk);
    check_out("lk_b1", 1'b1, 2'd1, 64'h211, 1'b0);
    req_last = 4'b0111;
    set_pl(1, 64'h212);
    check_rdy("lk_rdy2", 4'b0010);
    @(negedge clk);
    check_out("lk_b2", 1'b1, 2'd1, 64'h212, 1'b1);
    check_rdy("lk_next_grant2", 4'b0100);
    req_vld = '0;
    @(negedge clk);
    check("lk_drain", 64'(deq_vld), 64'h0);

    // Backpressure: deq_rdy low for 5 cycles, one beat 0xA5 held (rr_ptr=2)
    req_vld  = 4'b0001;
    req_last = 4'b0001;
    set_pl(0, 64'hA5);
    deq_rdy  = 1'b0;
    check_rdy("bp_rdy_first", 4'b0001);
    @(negedge clk);
    set_pl(0, 64'h5A);
    for (int k = 0; k < 4; k++) begin
      check_out("bp_hold", 1'b1, 2'd0, 64'hA5, 1'b1);
      check_rdy("bp_stall_rdy", 4'b0000);
      @(negedge clk);
    end
    deq_rdy = 1'b1;
    check_out("bp_release", 1'b1, 2'd0, 64'hA5, 1'b1);
    check_rdy("bp_release_rdy", 4'b0001);
    @(negedge clk);
    check_out("bp_next", 1'b1, 2'd0, 64'h5A, 1'b1);
    req_vld = '0;
    @(negedge clk);
    check("bp_drain", 64'(deq_vld), 64'h0);

    // Wrap and skip: drive rr_ptr to 3 via req2, then 4'b0101 (rr_ptr=1)
    req_vld  = 4'b0100;
    req_last = 4'b1111;
    set_pl(2, 64'h320);
    check_rdy("wr_rdy_r2", 4'b0100);
    @(negedge clk);
    check_out("wr_r2", 1'b1, 2'd2, 64'h320, 1'b1);
    req_vld = 4'b0101;
    set_pl(0, 64'h300);
    set_pl(2, 64'h321);
    check_rdy("wr_wrap_rdy", 4'b0001);
    @(negedge clk);
    check_out("wr_r0", 1'b1, 2'd0, 64'h300, 1'b1);
    check_rdy("wr_skip_rdy", 4'b0100);
    @(negedge clk);
    check_out("wr_r2b", 1'b1, 2'd2, 64'h321, 1'b1);
    req_vld = '0;
    @(negedge clk);

    // Flush mid-packet: req2 locked after one beat (rr_ptr=3)
    req_vld  = 4'b0100;
    req_last = 4'b0001;
    set_pl(2, 64'h420);
    check_rdy("fl_rdy_r2", 4'b0100);
    @(negedge clk);
    check_out("fl_b0", 1'b1, 2'd2, 64'h420, 1'b0);
    flush   = 1'b1;
    req_vld = 4'b0101;
    set_pl(0, 64'h400);
    check_rdy("fl_rdy_flush", 4'b0000);
    @(negedge clk);
    flush = 1'b0;
    check("fl_vld", 64'(deq_vld), 64'h0);
    check_rdy("fl_rdy_after", 4'b0001);
    @(negedge clk);
    check_out("fl_r0", 1'b1, 2'd0, 64'h400, 1'b1);

    // Async reset mid-packet: req3 locked (rr_ptr=1)
    req_vld  = 4'b1000;
    req_last = 4'b0000;
    set_pl(3, 64'h530);
    check_rdy("rs_rdy_r3", 4'b1000);
    @(negedge clk);
    check_out("rs_b0", 1'b1, 2'd3, 64'h530, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check_out("rs_async", 1'b0, 2'd0, 64'h0, 1'b0);
    @(negedge clk);
    rstn     = 1'b1;
    req_vld  = 4'b1001;
    req_last = 4'b1111;
    set_pl(0, 64'h500);
    check_rdy("rs_restart_rdy", 4'b0001);
    @(negedge clk);
    check_out("rs_r0", 1'b1, 2'd0, 64'h500, 1'b1);
    req_vld = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
